// File: rtl/step_dir_decoder.sv
// Receive-side STEP/DIR decoder: synchronizes an external step/dir pair, tracks a 24-bit wrapping position,
// measures step period and flags DIR setup violations. Define STEP_DIR_GLITCH_FILTER_EN to enable the STEP pulse-width filter.
module step_dir_decoder #(
    parameter int MIN_PULSE    = 50,
    parameter int DIR_SETUP    = 8,
    parameter int IDLE_TIMEOUT = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_in,
    input  logic        dir_in,
    input  logic        pos_load,
    input  logic [23:0] pos_value,
    input  logic        clear_err,
    output logic [23:0] position,
    output logic        step_stb,
    output logic [23:0] step_period,
    output logic        period_valid,
    output logic        moving,
    output logic [7:0]  glitch_count,
    output logic        dir_err
);

    localparam int AGE_W = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DIR_SETUP);
    localparam logic [23:0] TIMEOUT = 24'(IDLE_TIMEOUT);

`ifdef STEP_DIR_GLITCH_FILTER_EN
    localparam int HI_W = (MIN_PULSE < 2) ? 1 : $clog2(MIN_PULSE + 1);
    localparam logic [HI_W-1:0] HI_LAST = HI_W'(MIN_PULSE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        QUAL     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    logic [HI_W-1:0] hi_cnt, hi_nxt;
    logic            glitch;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd2
    } state_t;
`endif

    state_t state, state_nxt;

    logic             step_s1, step_s, step_prev;
    logic             dir_s1, dir_s, dir_prev;
    logic [1:0]       fill;
    logic             armed;
    logic             rise;
    logic             dir_lat;
    logic             step_dir;
    logic [AGE_W-1:0] dir_age_q, dir_age;
    logic             dir_viol;
    logic             accept;
    logic [23:0]      per_cnt;
    logic             have_first;

    // Edges are only trusted once the synchronizer has refilled after reset and STEP has been
    // seen low, so a pulse held across reset is never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_s1   <= 1'b0;
            step_s    <= 1'b0;
            step_prev <= 1'b0;
            dir_s1    <= 1'b0;
            dir_s     <= 1'b0;
            dir_prev  <= 1'b0;
            fill      <= 2'd0;
            armed     <= 1'b0;
        end else begin
            step_s1   <= step_in;
            step_s    <= step_s1;
            step_prev <= step_s;
            dir_s1    <= dir_in;
            dir_s     <= dir_s1;
            dir_prev  <= dir_s;
            if (fill != 2'd2) fill <= fill + 2'd1;
            if (fill == 2'd2 && !step_s) armed <= 1'b1;
        end
    end

    assign rise     = step_s & ~step_prev & armed;
    assign dir_age  = (dir_s != dir_prev) ? '0 : dir_age_q;
    assign dir_viol = rise && (dir_age < AGE_MAX);
    assign step_dir = rise ? dir_s : dir_lat;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
`ifdef STEP_DIR_GLITCH_FILTER_EN
        hi_nxt    = hi_cnt;
        glitch    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
`ifdef STEP_DIR_GLITCH_FILTER_EN
                    if (MIN_PULSE <= 1) begin
                        accept    = 1'b1;
                        state_nxt = WAIT_LOW;
                    end else begin
                        hi_nxt    = HI_W'(1);
                        state_nxt = QUAL;
                    end
`else
                    accept    = 1'b1;
                    state_nxt = WAIT_LOW;
`endif
                end
            end
`ifdef STEP_DIR_GLITCH_FILTER_EN
            QUAL: begin
                if (!step_s) begin
                    glitch    = 1'b1;
                    state_nxt = IDLE;
                end else if (hi_cnt == HI_LAST) begin
                    accept    = 1'b1;
                    state_nxt = WAIT_LOW;
                end else begin
                    hi_nxt = hi_cnt + HI_W'(1);
                end
            end
`endif
            WAIT_LOW: begin
                if (!step_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dir_lat      <= 1'b0;
            dir_age_q    <= '0;
            position     <= 24'd0;
            step_stb     <= 1'b0;
            step_period  <= 24'd0;
            period_valid <= 1'b0;
            moving       <= 1'b0;
            per_cnt      <= 24'd0;
            have_first   <= 1'b0;
            dir_err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_stb <= accept;
            if (rise) dir_lat <= dir_s;
            dir_age_q <= (dir_age < AGE_MAX) ? dir_age + AGE_W'(1) : AGE_MAX;

            if (pos_load)    position <= pos_value;
            else if (accept) position <= step_dir ? position - 24'd1 : position + 24'd1;

            if (accept)                per_cnt <= 24'd1;
            else if (per_cnt != '1)    per_cnt <= per_cnt + 24'd1;

            // The first accept after reset or an idle timeout only starts the period counter.
            if (accept) begin
                moving     <= 1'b1;
                have_first <= 1'b1;
                if (have_first) begin
                    step_period  <= per_cnt;
                    period_valid <= 1'b1;
                end
            end else if (per_cnt >= TIMEOUT) begin
                moving       <= 1'b0;
                period_valid <= 1'b0;
                have_first   <= 1'b0;
            end

            if (dir_viol)       dir_err <= 1'b1;
            else if (clear_err) dir_err <= 1'b0;
        end
    end

`ifdef STEP_DIR_GLITCH_FILTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt       <= '0;
            glitch_count <= 8'd0;
        end else begin
            hi_cnt <= hi_nxt;
            if (glitch) begin
                if (clear_err)                  glitch_count <= 8'd1;
                else if (glitch_count != 8'hFF) glitch_count <= glitch_count + 8'd1;
            end else if (clear_err) begin
                glitch_count <= 8'd0;
            end
        end
    end
`else
    assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: pulse-level reference model checked every cycle, plus literal checkpoints.
// Follows STEP_DIR_GLITCH_FILTER_EN the same way the design does.
module tb_step_dir_decoder;

    localparam int MIN_PULSE    = 50;
    localparam int DIR_SETUP    = 8;
    localparam int IDLE_TIMEOUT = 3000;
`ifdef STEP_DIR_GLITCH_FILTER_EN
    localparam int  QUAL_LEN = MIN_PULSE;
    localparam bit  FILT     = 1'b1;
`else
    localparam int  QUAL_LEN = 1;
    localparam bit  FILT     = 1'b0;
`endif

    logic        clk, reset, step_in, dir_in, pos_load, clear_err;
    logic [23:0] pos_value;
    logic [23:0] position, step_period;
    logic        step_stb, period_valid, moving, dir_err;
    logic [7:0]  glitch_count;

    step_dir_decoder #(
        .MIN_PULSE(MIN_PULSE), .DIR_SETUP(DIR_SETUP), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
        .pos_load(pos_load), .pos_value(pos_value), .clear_err(clear_err),
        .position(position), .step_stb(step_stb), .step_period(step_period),
        .period_valid(period_valid), .moving(moving), .glitch_count(glitch_count),
        .dir_err(dir_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int stb_seen = 0;

    // Reference model: pulses are described by their high-run length on the synchronized STEP.
    bit          m_valid = 0;
    int          cyc = 0;
    bit          q1, q2, qprev, g1, g2, arm;
    bit          d1, d2, dprev;
    int          chg, run, last_acc;
    bit          pdir, acc_seen, first_done;
    logic [23:0] e_pos, e_per;
    logic        e_stb, e_pv, e_mov, e_derr;
    logic [7:0]  e_gl;

    always @(posedge clk) begin
        bit new_pulse, accept, glitch_evt, viol;
        if (reset) begin
            q1 = 0; q2 = 0; qprev = 0; g1 = 0; g2 = 0; arm = 0;
            d1 = 0; d2 = 0; dprev = 0;
            chg = cyc + 1; run = 0; last_acc = 0;
            pdir = 0; acc_seen = 0; first_done = 0;
            e_pos = 0; e_per = 0; e_stb = 0; e_pv = 0; e_mov = 0; e_derr = 0; e_gl = 0;
            m_valid = 1;
        end else begin
            if (d2 != dprev) chg = cyc;
            new_pulse = q2 && !qprev && arm;
            glitch_evt = 0; viol = 0;
            if (new_pulse) begin
                run = 1;
                pdir = d2;
                if (cyc - chg < DIR_SETUP) viol = 1;
            end else if (q2 && run > 0 && run <= QUAL_LEN) begin
                run++;
            end else if (!q2) begin
                if (run > 0 && run < QUAL_LEN) glitch_evt = 1;
                run = 0;
            end
            accept = q2 && (run == QUAL_LEN);

            e_stb = accept;
            if (pos_load)    e_pos = pos_value;
            else if (accept) e_pos = pdir ? e_pos - 24'd1 : e_pos + 24'd1;

            if (accept) begin
                if (first_done) begin
                    e_per = 24'(cyc - last_acc);
                    e_pv  = 1;
                end
                first_done = 1; e_mov = 1; last_acc = cyc; acc_seen = 1;
            end else if (acc_seen && (cyc - last_acc) >= IDLE_TIMEOUT) begin
                e_mov = 0; e_pv = 0; first_done = 0;
            end

            if (viol)           e_derr = 1;
            else if (clear_err) e_derr = 0;

            if (glitch_evt)     e_gl = clear_err ? 8'd1 : ((e_gl == 8'hFF) ? e_gl : e_gl + 8'd1);
            else if (clear_err) e_gl = 8'd0;

            if (!q2 && g2) arm = 1;
            qprev = q2; q2 = q1; q1 = step_in;
            dprev = d2; d2 = d1; d1 = dir_in;
            g2 = g1; g1 = 1;
        end
        cyc++;
        #1;
        if (m_valid) begin
            n_vec++;
            if (step_stb === 1'b1) stb_seen++;
            if (position !== e_pos || step_stb !== e_stb || step_period !== e_per ||
                period_valid !== e_pv || moving !== e_mov || dir_err !== e_derr ||
                glitch_count !== e_gl) begin
                n_bad++;
                $display("FAIL model cycle %0d: got pos=%h stb=%b per=%0d pv=%b mov=%b derr=%b gl=%0d expected pos=%h stb=%b per=%0d pv=%b mov=%b derr=%b gl=%0d",
                         cyc, position, step_stb, step_period, period_valid, moving, dir_err, glitch_count,
                         e_pos, e_stb, e_per, e_pv, e_mov, e_derr, e_gl);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        step_in = 1'b1;
        repeat (hi) @(negedge clk);
        step_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; step_in = 1'b0; dir_in = 1'b0;
        pos_load = 1'b0; pos_value = 24'd0; clear_err = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        idle(20);
        check("rst_position", position, 0);
        check("rst_moving", moving, 0);
        check("rst_period_valid", period_valid, 0);

        // 10 increments at a 1000-cycle period
        stb_seen = 0;
        for (int i = 0; i < 10; i++) begin
            pulse(100, 900);
            if (i == 0) check("pv_after_first", period_valid, 0);
            if (i == 1) check("pv_after_second", period_valid, 1);
        end
        check("run_position", position, 10);
        check("run_stb_count", stb_seen, 10);
        check("run_period", step_period, 1000);
        check("run_period_valid", period_valid, 1);
        check("run_moving", moving, 1);

        // decrement across zero
        pos_value = 24'd3; pos_load = 1'b1;
        @(negedge clk);
        pos_load = 1'b0;
        dir_in = 1'b1;
        idle(20);
        for (int i = 0; i < 5; i++) pulse(100, 100);
        check("wrap_position", position, 24'hFFFFFE);
        check("wrap_dir_err", dir_err, 0);

        // short pulse followed by a long one
        dir_in = 1'b0;
        idle(20);
        pulse(20, 200);
        pulse(60, 200);
        check("glitch_position", position, FILT ? 24'hFFFFFF : 24'h000000);
        check("glitch_count", glitch_count, FILT ? 1 : 0);

        // DIR changed 3 cycles ahead of STEP
        dir_in = 1'b1;
        idle(3);
        pulse(100, 100);
        check("dirv_err", dir_err, 1);
        check("dirv_position", position, FILT ? 24'hFFFFFE : 24'hFFFFFF);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        idle(5);
        check("clr_dir_err", dir_err, 0);
        check("clr_glitch", glitch_count, 0);

        // clear_err lands on the same edge as a fresh violation
        dir_in = 1'b0;
        idle(3);
        step_in = 1'b1;
        idle(2);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        idle(97);
        step_in = 1'b0;
        idle(100);
        check("clr_vs_set_err", dir_err, 1);
        check("clr_vs_set_position", position, FILT ? 24'hFFFFFF : 24'h000000);

        // preload on the accept edge
        idle(20);
        pos_value = 24'h001000;
        step_in = 1'b1;
        idle(QUAL_LEN + 1);
        pos_load = 1'b1;
        @(posedge clk);
        #2;
        check("load_stb", step_stb, 1);
        check("load_position", position, 24'h001000);
        @(negedge clk);
        pos_load = 1'b0;
        idle(100 - QUAL_LEN - 2);
        step_in = 1'b0;
        idle(50);
        check("load_hold", position, 24'h001000);
        check("load_moving", moving, 1);

        // idle timeout, then restart as a first step
        idle(IDLE_TIMEOUT + 50);
        check("timeout_moving", moving, 0);
        check("timeout_pv", period_valid, 0);
        pulse(100, 100);
        check("restart_moving", moving, 1);
        check("restart_pv", period_valid, 0);

        // reset in the middle of a high STEP
        step_in = 1'b1;
        idle(20);
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(200);
        check("rstmid_position", position, 0);
        check("rstmid_period", step_period, 0);
        check("rstmid_moving", moving, 0);
        check("rstmid_dir_err", dir_err, 0);
        check("rstmid_glitch", glitch_count, 0);
        step_in = 1'b0;
        idle(50);
        pulse(100, 100);
        check("rstmid_next_pulse", position, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
